and_equiv_test_sequencer: RTL and testbench
===========================================

// Module: and_equiv_test_sequencer
// PURPOSE
//  Sequences the on-board equivalence test of the NINPUTS-wide AND implementations
//  (behavioural, LUT, LUT+carry-chain).
//  - Generates directed test vectors and drives the shared input bus.
//  - Waits for the outputs to settle, then checks all three against the expected AND.
//  - Keeps a saturating error count and sticky failure information.
//  - Paces each vector with the display's done pulse so a human can watch it.
//  Sits between the display timer and the three AND datapaths in the board top level.
// PARAMETERS
//  NINPUTS        32   width of the AND input vector (>=2)
//  IDX_W          8    width of vector index / first_err_idx; 2**IDX_W > 2*NINPUTS+NCOUNT
//  NCOUNT         16   number of binary-count vectors in phase 2 (<=2**IDX_W)
//  SETTLE_CYCLES  2    clocks between applying a vector and checking it (>=1)
//  MAXERROR       9    saturation value of err_count (<=15)
//  PACED          1    1: wait for step before the next vector; 0: advance without waiting
// PORTS
//  clk            in   1        system clock; all logic on its rising edge
//  rst_n          in   1        synchronous reset, active low
//  start          in   1        start (or restart from DONE) the test; level-sampled
//  step           in   1        one-cycle done pulse from the display timer
//  dut_o          in   3        {o3,o2,o1}: outputs of the three AND implementations
//  vec_out        out  NINPUTS  vector driven onto the AND inputs
//  busy           out  1        high in every state except IDLE and DONE
//  done           out  1        high in DONE
//  phase          out  2        0 walk-1, 1 walk-0, 2 count, 3 LFSR
//  err_count      out  4        saturating count of failing vectors
//  first_err_idx  out  IDX_W    global index of the first failing vector (all-ones if none)
//  mism_mask      out  3        sticky OR of the per-implementation mismatch bits
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - state=IDLE.
//    - vec_out, busy, done, phase, err_count, mism_mask and the vector index all = 0.
//    - first_err_idx = all ones.
//    - Reset has priority in every state, including mid-test.
//  - FSM: IDLE -> APPLY -> SETTLE -> CHECK -> WAIT_STEP -> APPLY ... -> DONE.
//    - IDLE: start=1 clears the counters and the first-error record; next state APPLY, phase 0, idx 0.
//    - APPLY (1 cycle): load vec_out for the current phase/index; next state SETTLE.
//    - SETTLE: stays for SETTLE_CYCLES cycles; next state CHECK.
//    - CHECK (1 cycle):
//      - exp = &vec_out; mis[i] = dut_o[i] ^ exp.
//      - If mis != 0:
//        - err_count += 1 unless already at MAXERROR.
//        - mism_mask |= mis.
//        - first_err_idx <= global idx, only if still all ones.
//    - WAIT_STEP:
//      - PACED=1: leave on step=1. PACED=0: leave the cycle after entry.
//      - Next is APPLY with the next vector, or DONE after the last vector of the last phase.
//    - DONE: holds all results and vec_out.
//      - start=1 restarts the test exactly as from IDLE.
//      - Otherwise stays in DONE.
//  - Vector patterns; the global idx counts continuously across phases:
//    - phase 0 (walk-1): 1<<k for k=0..NINPUTS-1. Exp=0.
//    - phase 1 (walk-0): ~(1<<k) for k=0..NINPUTS-1, then all ones. NINPUTS+1 vectors.
//    - phase 2 (count): k for k=0..NCOUNT-1, zero-extended.
//    - phase 3 (LFSR): only with LFSR_PHASE_EN.
//  - Latency: each vector reaches its CHECK cycle SETTLE_CYCLES+1 cycles after APPLY.
//  - Ignored inputs:
//    - start while busy.
//    - step outside WAIT_STEP.
//    - A step coincident with CHECK is lost; the display re-pulses.
//  - Saturation:
//    - err_count never wraps; holds at MAXERROR.
//    - The idx counter wraps modulo 2**IDX_W; the parameter rule prevents this in normal use.
// CONFIGURATION
//  LFSR_PHASE_EN defined:
//    - Phase 3 applies 64 pseudo-random vectors.
//    - Source: NINPUTS-bit Galois LFSR, seed 32'hACE1_0001 truncated/extended; shifts once per APPLY.
//    - Every 8th vector (k%8==7) is forced to all ones so exp=1 is exercised.
//    - DONE follows phase 3.
//  LFSR_PHASE_EN undefined:
//    - DONE follows phase 2.
//    - The LFSR logic is absent; phase never reaches 3.
// TESTING
//  1 rst_n=0 for 2 clk with start=1
//    -> state IDLE, vec_out=0, err_count=0, first_err_idx=8'hFF, done=0.
//  2 NINPUTS=32, PACED=0, three correct AND models, start pulse
//    -> 65+16=81 vectors, done=1, err_count=0, mism_mask=0.
//    -> walk-0 phase ends with vec_out=32'hFFFF_FFFF.
//  3 Force o2 stuck-at-1, PACED=0
//    -> first_err_idx=0 (vector 32'h1), mism_mask=3'b010, err_count=9 (saturated).
//  4 PACED=1, step held 0 for 100 cycles
//    -> sequencer stays in WAIT_STEP with vector 0.
//    -> one step pulse -> vec_out=32'h2 two cycles later.
//  5 rst_n=0 mid-phase 1, then start again
//    -> all outputs at reset values, restart from vec_out=32'h1.
//    -> start pulses while busy have no effect.
//  6 LFSR_PHASE_EN defined, all correct
//    -> phase reaches 3, 145 vectors total, err_count=0, done=1.

Source files
------------

// File: rtl/and_equiv_test_sequencer.sv
// Drives directed vectors onto three NINPUTS-wide AND implementations and checks their outputs.
// Define LFSR_PHASE_EN to add a 64-vector pseudo-random phase 3 after the count phase.
module and_equiv_test_sequencer #(
    parameter int NINPUTS       = 32,
    parameter int IDX_W         = 8,
    parameter int NCOUNT        = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAXERROR      = 9,
    parameter bit PACED         = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [2:0]         dut_o,
    output logic [NINPUTS-1:0] vec_out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         phase,
    output logic [3:0]         err_count,
    output logic [IDX_W-1:0]   first_err_idx,
    output logic [2:0]         mism_mask
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`ifdef LFSR_PHASE_EN
    localparam logic [1:0] LAST_PHASE = 2'd3;
    localparam logic [NINPUTS-1:0] SEED = NINPUTS'(32'hACE1_0001);
    localparam logic [NINPUTS-1:0] TAPS = {1'b1, {(NINPUTS-1){1'b0}}} | NINPUTS'(32'h0020_0003);
`else
    localparam logic [1:0] LAST_PHASE = 2'd2;
`endif

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, WAIT_STEP, DONE} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx;        // global index across all phases
    logic [IDX_W-1:0]   k;          // index within the current phase
    logic [SW-1:0]      settle_cnt;
    logic               last_in_phase, last_vec, adv;
    logic [NINPUTS-1:0] one_hot, pattern;
    logic [2:0]         mis;

`ifdef LFSR_PHASE_EN
    logic [NINPUTS-1:0] lfsr, lfsr_next;
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
`endif

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign mis  = dut_o ^ {3{&vec_out}};

    always_comb begin
        last_in_phase = 1'b0;
        case (phase)
            2'd0:    last_in_phase = (k == IDX_W'(NINPUTS - 1));
            2'd1:    last_in_phase = (k == IDX_W'(NINPUTS));
            2'd2:    last_in_phase = (k == IDX_W'(NCOUNT - 1));
            default: last_in_phase = (k == IDX_W'(63));
        endcase
        last_vec = last_in_phase && (phase == LAST_PHASE);
    end

    always_comb begin
        one_hot = NINPUTS'(1) << k;
        pattern = '0;
        case (phase)
            2'd0:    pattern = one_hot;
            2'd1:    pattern = (k == IDX_W'(NINPUTS)) ? '1 : ~one_hot;
            2'd2:    pattern = NINPUTS'(k);
`ifdef LFSR_PHASE_EN
            // every 8th random vector is all ones so the exp=1 path is exercised
            default: pattern = (k[2:0] == 3'b111) ? '1 : lfsr_next;
`else
            default: pattern = '0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        adv     = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_d = APPLY;
            APPLY:      state_d = SETTLE;
            SETTLE:     if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_d = CHECK;
            CHECK:      state_d = WAIT_STEP;
            WAIT_STEP: begin
                if (!PACED || step) begin
                    adv     = 1'b1;
                    state_d = last_vec ? DONE : APPLY;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_out       <= '0;
            phase         <= '0;
            idx           <= '0;
            k             <= '0;
            settle_cnt    <= '0;
            err_count     <= '0;
            mism_mask     <= '0;
            first_err_idx <= '1;
`ifdef LFSR_PHASE_EN
            lfsr          <= SEED;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        phase         <= '0;
                        idx           <= '0;
                        k             <= '0;
                        err_count     <= '0;
                        mism_mask     <= '0;
                        first_err_idx <= '1;
`ifdef LFSR_PHASE_EN
                        lfsr          <= SEED;
`endif
                    end
                end
                APPLY: begin
                    vec_out    <= pattern;
                    settle_cnt <= '0;
`ifdef LFSR_PHASE_EN
                    if (phase == 2'd3) lfsr <= lfsr_next;
`endif
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                CHECK: begin
                    if (|mis) begin
                        if (err_count != 4'(MAXERROR)) err_count <= err_count + 4'd1;
                        mism_mask <= mism_mask | mis;
                        if (first_err_idx == '1) first_err_idx <= idx;
                    end
                end
                WAIT_STEP: begin
                    if (adv && !last_vec) begin
                        idx <= idx + 1'b1;
                        if (last_in_phase) begin
                            phase <= phase + 2'd1;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_and_equiv_test_sequencer.sv
// Scoreboard bench: expected vector stream is queued at start, a monitor pops it on every new vector.
module tb_and_equiv_test_sequencer;

`ifdef LFSR_PHASE_EN
    localparam logic [1:0] LAST_PH = 2'd3;
`else
    localparam logic [1:0] LAST_PH = 2'd2;
`endif

    typedef struct {
        logic [31:0] v;
        bit          care;
    } exp_t;

    logic        clk = 0;
    logic        rst_n, start, step, stuck;
    logic [2:0]  dut_o;
    logic [31:0] vec_out;
    logic        busy, done;
    logic [1:0]  phase;
    logic [3:0]  err_count;
    logic [7:0]  first_err_idx;
    logic [2:0]  mism_mask;

    logic        start_p, step_p;
    logic [2:0]  dut_o_p;
    logic [31:0] vec_out_p;
    logic        busy_p, done_p;
    logic [1:0]  phase_p;
    logic [3:0]  err_count_p;
    logic [7:0]  first_err_idx_p;
    logic [2:0]  mism_mask_p;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic [31:0] prev_vec = '0;

    always #5 clk = ~clk;

    // reference AND models; o2 can be forced stuck-at-1
    assign dut_o   = {&vec_out, stuck ? 1'b1 : &vec_out, &vec_out};
    assign dut_o_p = {3{&vec_out_p}};

    and_equiv_test_sequencer #(.NINPUTS(32), .IDX_W(8), .NCOUNT(16), .SETTLE_CYCLES(2),
                               .MAXERROR(9), .PACED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .dut_o(dut_o),
        .vec_out(vec_out), .busy(busy), .done(done), .phase(phase),
        .err_count(err_count), .first_err_idx(first_err_idx), .mism_mask(mism_mask));

    and_equiv_test_sequencer #(.NINPUTS(32), .IDX_W(8), .NCOUNT(16), .SETTLE_CYCLES(2),
                               .MAXERROR(9), .PACED(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .start(start_p), .step(step_p), .dut_o(dut_o_p),
        .vec_out(vec_out_p), .busy(busy_p), .done(done_p), .phase(phase_p),
        .err_count(err_count_p), .first_err_idx(first_err_idx_p), .mism_mask(mism_mask_p));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq();
        exp_t e;
        e.care = 1'b1;
        for (int i = 0; i < 32; i++) begin e.v = 32'h1 << i; exp_q.push_back(e); end
        for (int i = 0; i < 32; i++) begin e.v = ~(32'h1 << i); exp_q.push_back(e); end
        e.v = 32'hFFFF_FFFF; exp_q.push_back(e);
        for (int i = 0; i < 16; i++) begin e.v = 32'(i); exp_q.push_back(e); end
`ifdef LFSR_PHASE_EN
        for (int i = 0; i < 64; i++) begin
            e.care = (i % 8 == 7);
            e.v    = 32'hFFFF_FFFF;
            exp_q.push_back(e);
        end
`endif
    endtask

    task automatic launch();
        push_seq();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input logic [3:0] e_err,
                              input logic [2:0] e_mask, input logic [7:0] e_first);
        int n = 0;
        while (!done && n < 3000) begin @(posedge clk); #1; n++; end
        chk({tag, ":done"}, 64'(done), 64'(1));
        chk({tag, ":vectors_left"}, 64'(exp_q.size()), 64'(0));
        chk({tag, ":err_count"}, 64'(err_count), 64'(e_err));
        chk({tag, ":mism_mask"}, 64'(mism_mask), 64'(e_mask));
        chk({tag, ":first_err_idx"}, 64'(first_err_idx), 64'(e_first));
        chk({tag, ":phase"}, 64'(phase), 64'(LAST_PH));
        chk({tag, ":busy"}, 64'(busy), 64'(0));
    endtask

    // monitor: each new vector presented while busy is popped and compared
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy && vec_out != prev_vec) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL vec_underflow: got %0h expected no further vector", vec_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.care) chk("vec", 64'(vec_out), 64'(e.v));
                end
            end
            prev_vec = vec_out;
        end
    end

    initial begin
        int n;
        rst_n = 0; start = 1; start_p = 1; step = 0; step_p = 0; stuck = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst:vec_out", 64'(vec_out), 64'(0));
        chk("rst:err_count", 64'(err_count), 64'(0));
        chk("rst:first_err_idx", 64'(first_err_idx), 64'hFF);
        chk("rst:done", 64'(done), 64'(0));
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:phase", 64'(phase), 64'(0));
        chk("rst:mism_mask", 64'(mism_mask), 64'(0));
        chk("rst:paced_vec_out", 64'(vec_out_p), 64'(0));
        rst_n = 1; start = 0; start_p = 0;
        @(posedge clk); #1;
        chk("idle:busy", 64'(busy), 64'(0));

        launch();
        finish_run("clean", 4'd0, 3'b000, 8'hFF);

        stuck = 1;
        launch();
        finish_run("stuck_o2", 4'd9, 3'b010, 8'h00);
        stuck = 0;

        // paced instance: must wait on step with vector 0
        start_p = 1; @(posedge clk); #1; start_p = 0;
        n = 0;
        while (vec_out_p != 32'h1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("paced:first_vec", 64'(vec_out_p), 64'h1);
        repeat (100) @(posedge clk); #1;
        chk("paced:hold_vec", 64'(vec_out_p), 64'h1);
        chk("paced:hold_busy", 64'(busy_p), 64'(1));
        step_p = 1;
        @(posedge clk); #1;
        step_p = 0;
        chk("paced:step+1", 64'(vec_out_p), 64'h1);
        @(posedge clk); #1;
        chk("paced:step+2", 64'(vec_out_p), 64'h2);
        step_p = 1;
        @(posedge clk); #1;
        step_p = 0;
        repeat (20) @(posedge clk); #1;
        chk("paced:step_outside_wait", 64'(vec_out_p), 64'h2);
        chk("paced:err_count", 64'(err_count_p), 64'(0));

        // reset mid phase 1, with an ignored start while busy
        launch();
        n = 0;
        while (phase != 2'd1 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("mid:phase1", 64'(phase), 64'(1));
        repeat (12) @(posedge clk); #1;
        start = 1; @(posedge clk); #1; start = 0;
        repeat (12) @(posedge clk); #1;
        chk("mid:start_ignored_phase", 64'(phase), 64'(1));
        chk("mid:busy", 64'(busy), 64'(1));
        rst_n = 0;
        @(posedge clk); #1;
        chk("mid_rst:vec_out", 64'(vec_out), 64'(0));
        chk("mid_rst:phase", 64'(phase), 64'(0));
        chk("mid_rst:busy", 64'(busy), 64'(0));
        chk("mid_rst:first_err_idx", 64'(first_err_idx), 64'hFF);
        chk("mid_rst:paced_busy", 64'(busy_p), 64'(0));
        rst_n = 1;
        exp_q.delete();
        launch();
        finish_run("restart", 4'd0, 3'b000, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
